// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx between NUM_REQ byte producers over valid/ready.
// Build option UART_ARB_FIXED_PRIO_EN selects lowest-index-wins instead of round-robin.
module uart_tx_arbiter #(
  parameter int  NUM_REQ       = 4,
  parameter int  DATA_W        = 8,
  parameter int  START_TIMEOUT = 15,
  localparam int GID_W         = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_start,
  input  logic                      tx_busy,
  output logic [GID_W-1:0]          grant_id,
  output logic                      active,
  output logic                      err_timeout
);

  localparam int CNT_W = (START_TIMEOUT > 2) ? $clog2(START_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);
  localparam logic [GID_W-1:0] LAST_IDX = GID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic [GID_W-1:0]   grant_id_q, grant_id_d;
  logic               active_q, active_d;
  logic               err_timeout_q, err_timeout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [GID_W-1:0]   win_idx;
  logic               win_found;
  logic               grant_ok;

`ifndef UART_ARB_FIXED_PRIO_EN
  localparam int GX_W = GID_W + 1;
  localparam logic [GX_W-1:0] NUM_REQ_X = GX_W'(NUM_REQ);

  logic [GID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [GX_W-1:0]  cand;

  // Search starts at rr_ptr; wrap uses an explicit subtract so non-power-of-two counts work.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + GX_W'(i);
      if (cand >= NUM_REQ_X) cand = cand - NUM_REQ_X;
      if (!win_found && req_valid[cand[GID_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[GID_W-1:0];
      end
    end
  end
`else
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && req_valid[i]) begin
        win_found = 1'b1;
        win_idx   = GID_W'(i);
      end
    end
  end
`endif

  // Ready is gated by rst_n so nothing is offered while the block is held in reset.
  assign grant_ok = rst_n && (state_q == IDLE) && !tx_busy && win_found;

  always_comb begin
    req_ready = '0;
    if (grant_ok) req_ready[win_idx] = 1'b1;
  end

  always_comb begin
    state_d       = state_q;
    tx_data_d     = tx_data_q;
    tx_start_d    = tx_start_q;
    grant_id_d    = grant_id_q;
    active_d      = active_q;
    err_timeout_d = 1'b0;
    cnt_d         = cnt_q;
`ifndef UART_ARB_FIXED_PRIO_EN
    rr_ptr_d      = rr_ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_ok) begin
          tx_data_d  = req_data[win_idx*DATA_W +: DATA_W];
          grant_id_d = win_idx;
          tx_start_d = 1'b1;
          active_d   = 1'b1;
          cnt_d      = '0;
          state_d    = START;
`ifndef UART_ARB_FIXED_PRIO_EN
          rr_ptr_d   = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
`endif
        end
      end
      START: begin
        if (tx_busy) begin
          tx_start_d = 1'b0;
          cnt_d      = '0;
          state_d    = BUSY;
        end else if (cnt_q == CNT_LAST) begin
          // Transmitter never acknowledged: drop the byte and flag it.
          tx_start_d    = 1'b0;
          active_d      = 1'b0;
          err_timeout_d = 1'b1;
          cnt_d         = '0;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BUSY: begin
        if (!tx_busy) begin
          active_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      tx_data_q     <= '0;
      tx_start_q    <= 1'b0;
      grant_id_q    <= '0;
      active_q      <= 1'b0;
      err_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      tx_data_q     <= tx_data_d;
      tx_start_q    <= tx_start_d;
      grant_id_q    <= grant_id_d;
      active_q      <= active_d;
      err_timeout_q <= err_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

`ifndef UART_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end
`endif

  assign tx_data     = tx_data_q;
  assign tx_start    = tx_start_q;
  assign grant_id    = grant_id_q;
  assign active      = active_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NUM_REQ=4, DATA_W=8, START_TIMEOUT=15).
// The bench plays the uart_tx role by driving tx_busy by hand.
module tb_uart_tx_arbiter;

`ifdef UART_ARB_FIXED_PRIO_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        active;
  logic        err_timeout;

  int errorCount = 0;
  int checkCount = 0;

  uart_tx_arbiter #(
    .NUM_REQ      (4),
    .DATA_W       (8),
    .START_TIMEOUT(15)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .grant_id   (grant_id),
    .active     (active),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      errorCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic busy);
    req_valid = valid;
    tx_busy   = busy;
  endtask

  // Advance to 2 time units after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] oneHot(input int idx);
    logic [31:0] v;
    v = 32'd1 << idx;
    return v;
  endfunction

  // One complete frame from IDLE with a short busy window; returns in IDLE.
  task automatic runFrame(input int gid);
    #1;
    checkOutput("frame_ready", 32'(req_ready), oneHot(gid));
    cyc();
    checkOutput("frame_start", 32'(tx_start), 32'd1);
    checkOutput("frame_data", 32'(tx_data), 32'h10 + 32'(gid));
    checkOutput("frame_gid", 32'(grant_id), 32'(gid));
    tx_busy = 1'b1;
    cyc();
    checkOutput("frame_start_drop", 32'(tx_start), 32'd0);
    checkOutput("frame_active", 32'(active), 32'd1);
    checkOutput("frame_busy_ready", 32'(req_ready), 32'd0);
    cyc();
    cyc();
    tx_busy = 1'b0;
    cyc();
    checkOutput("frame_active_end", 32'(active), 32'd0);
  endtask

  initial begin
    rst_n    = 1'b1;
    req_data = {8'h13, 8'hA5, 8'h11, 8'h10};
    applyStimulus(4'b1111, 1'b0);
    #1 rst_n = 1'b0;
    #2;
    // Ready must stay low during reset even with every requester valid.
    checkOutput("rst_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_outs", 32'({tx_start, active, err_timeout, grant_id, tx_data}), 32'd0);

    applyStimulus(4'b0000, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cyc();
      checkOutput("idle_quiet", 32'({req_ready, tx_start, active, err_timeout, grant_id, tx_data}), 32'd0);
    end

    // Single request on requester 2 with a long busy window.
    applyStimulus(4'b0100, 1'b0);
    #1;
    checkOutput("t2_ready", 32'(req_ready), 32'h4);
    cyc();
    req_valid = 4'b0000;
    checkOutput("t2_start", 32'(tx_start), 32'd1);
    checkOutput("t2_data", 32'(tx_data), 32'hA5);
    checkOutput("t2_gid", 32'(grant_id), 32'd2);
    checkOutput("t2_active", 32'(active), 32'd1);
    cyc();
    checkOutput("t2_start_hold1", 32'(tx_start), 32'd1);
    cyc();
    tx_busy = 1'b1;
    checkOutput("t2_start_hold2", 32'(tx_start), 32'd1);
    cyc();
    checkOutput("t2_start_drop", 32'(tx_start), 32'd0);
    checkOutput("t2_active_busy", 32'(active), 32'd1);
    repeat (99) cyc();
    checkOutput("t2_active_long", 32'(active), 32'd1);
    checkOutput("t2_err_none", 32'(err_timeout), 32'd0);
    tx_busy = 1'b0;
    cyc();
    checkOutput("t2_active_end", 32'(active), 32'd0);

    // Brief async reset so the rotation starts from requester 0.
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    applyStimulus(4'b1111, 1'b0);
    for (int k = 0; k < 5; k++) runFrame(FIXED_PRIO ? 0 : k % 4);

    // Transmitter never raises busy: timeout after 15 cycles.
    #1;
    checkOutput("to_ready", 32'(req_ready), oneHot(FIXED_PRIO ? 0 : 1));
    cyc();
    checkOutput("to_start", 32'(tx_start), 32'd1);
    checkOutput("to_gid", 32'(grant_id), FIXED_PRIO ? 32'd0 : 32'd1);
    for (int k = 1; k < 15; k++) begin
      cyc();
      checkOutput("to_wait", 32'({err_timeout, tx_start, active}), 32'b011);
    end
    cyc();
    checkOutput("to_pulse", 32'({err_timeout, tx_start, active}), 32'b100);
    #1;
    checkOutput("to_next_ready", 32'(req_ready), oneHot(FIXED_PRIO ? 0 : 2));
    cyc();
    checkOutput("to_pulse_end", 32'(err_timeout), 32'd0);
    checkOutput("to_next_start", 32'(tx_start), 32'd1);
    checkOutput("to_next_gid", 32'(grant_id), FIXED_PRIO ? 32'd0 : 32'd2);
    checkOutput("to_next_data", 32'(tx_data), FIXED_PRIO ? 32'h10 : 32'h12);

    // Reset asserted mid-cycle while in BUSY.
    tx_busy = 1'b1;
    cyc();
    checkOutput("rb_busy_active", 32'(active), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("rb_clear", 32'({tx_start, active, grant_id, tx_data}), 32'd0);
    checkOutput("rb_ready", 32'(req_ready), 32'd0);
    tx_busy = 1'b0;
    cyc();
    rst_n = 1'b1;
    #1;
    checkOutput("rb_rr_zero", 32'(req_ready), 32'h1);
    checkOutput("rb_err_none", 32'(err_timeout), 32'd0);

    // External busy in IDLE blocks ready; release shows ready the same cycle.
    applyStimulus(4'b0001, 1'b1);
    #1;
    checkOutput("eb_ready_blocked", 32'(req_ready), 32'd0);
    cyc();
    cyc();
    checkOutput("eb_still_blocked", 32'({req_ready, tx_start, active}), 32'd0);
    tx_busy = 1'b0;
    #1;
    checkOutput("eb_ready_release", 32'(req_ready), 32'h1);
    cyc();
    checkOutput("eb_start", 32'(tx_start), 32'd1);
    checkOutput("eb_data", 32'(tx_data), 32'h10);
    checkOutput("eb_gid", 32'(grant_id), 32'd0);

    // One-cycle busy pulse still passes through BUSY, then requester 0 is served again.
    tx_busy = 1'b1;
    cyc();
    checkOutput("p1_start_drop", 32'(tx_start), 32'd0);
    checkOutput("p1_active", 32'(active), 32'd1);
    tx_busy = 1'b0;
    cyc();
    checkOutput("p1_active_end", 32'(active), 32'd0);
    #1;
    checkOutput("p1_ready_again", 32'(req_ready), 32'h1);
    cyc();
    checkOutput("p1_start_again", 32'(tx_start), 32'd1);
    checkOutput("p1_gid_again", 32'(grant_id), 32'd0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
